// File: rtl/dsp_stim_player_if.sv
// Host/DSP-side signal bundle for the stimulus player.
// master = host and DSP sink, slave = the player itself.
interface dsp_stim_player_if #(
  parameter int DW  = 64,
  parameter int AW  = 10,
  parameter int LCW = 16
);
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [AW:0]    len;
  logic [LCW-1:0] nloops;
  logic           start;
  logic           stop;
  logic [DW-1:0]  dout;
  logic           dout_valid;
  logic           busy;
  logic           done;
  logic [LCW-1:0] pass_cnt;

  modport master (
    output wr_en, wr_addr, wr_data,
    output len, nloops, start, stop,
    input  dout, dout_valid, busy,
    input  done, pass_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  len, nloops, start, stop,
    output dout, dout_valid, busy,
    output done, pass_cnt
  );
endinterface

// File: rtl/dsp_stim_player.sv
// Replays a preloaded sample RAM into the DSP path, 1/clk.
// STIM_HOLD_LAST_EN: dout holds last sample when idle.
module dsp_stim_player #(
  parameter int DW  = 64,
  parameter int AW  = 10,
  parameter int LCW = 16
) (
  input logic               clk,
  input logic               rst,
  dsp_stim_player_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DRAIN
  } state_t;

  localparam logic [AW-1:0]  A_ONE  = 1;
  localparam logic [AW:0]    L_ONE  = 1;
  localparam logic [LCW-1:0] LC_ONE = 1;

  state_t         r_state, w_next;
  logic [DW-1:0]  r_mem [2**AW];
  logic [DW-1:0]  r_ram_q;
  logic [AW-1:0]  r_raddr, w_raddr_nx;
  logic [AW:0]    r_len;
  logic [LCW-1:0] r_nloops;
  logic [LCW-1:0] r_rd_pass, w_rd_pass_nx;
  logic           r_rd_v, r_rd_eop, r_rd_fin;
  logic [DW-1:0]  r_dout;
  logic           r_dout_valid;
  logic           r_out_fin;
  logic           r_done;
  logic [LCW-1:0] r_pass_cnt;

  logic w_accept, w_abort, w_issue;
  logic w_eop, w_fin, w_emit;

  assign w_accept = (r_state == IDLE) && bus.start
                    && (bus.len != '0);
  assign w_abort  = (r_state != IDLE) && bus.stop;
  assign w_issue  = (r_state == PLAY);
  assign w_eop    = w_issue
                    && ({1'b0, r_raddr} == r_len - L_ONE);
  assign w_fin    = w_eop && (r_nloops != '0)
                    && (r_rd_pass == r_nloops - LC_ONE);
  assign w_emit   = r_rd_v && !w_abort;

  always_comb begin
    w_next       = r_state;
    w_raddr_nx   = r_raddr;
    w_rd_pass_nx = r_rd_pass;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next       = PLAY;
          w_raddr_nx   = '0;
          w_rd_pass_nx = '0;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          w_next = IDLE;
        end else if (w_eop) begin
          w_raddr_nx   = '0;
          w_rd_pass_nx = r_rd_pass + LC_ONE;
          if (w_fin) w_next = DRAIN;
        end else begin
          w_raddr_nx = r_raddr + A_ONE;
        end
      end
      DRAIN: begin
        if (bus.stop || r_out_fin) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Read-first RAM: write port is never blocked by playback
  always_ff @(posedge clk) begin
    if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
    r_ram_q <= r_mem[r_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_raddr      <= '0;
      r_len        <= '0;
      r_nloops     <= '0;
      r_rd_pass    <= '0;
      r_rd_v       <= 1'b0;
      r_rd_eop     <= 1'b0;
      r_rd_fin     <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_out_fin    <= 1'b0;
      r_done       <= 1'b0;
      r_pass_cnt   <= '0;
    end else begin
      r_state   <= w_next;
      r_raddr   <= w_raddr_nx;
      r_rd_pass <= w_rd_pass_nx;
      if (w_accept) begin
        r_len    <= bus.len;
        r_nloops <= bus.nloops;
      end
      r_done <= (r_state == DRAIN) && r_out_fin
                && !bus.stop;
      r_rd_v       <= w_issue && !w_abort;
      r_rd_eop     <= w_eop;
      r_rd_fin     <= w_fin;
      r_dout_valid <= w_emit;
      r_out_fin    <= w_emit && r_rd_fin;
      if (w_accept)
        r_pass_cnt <= '0;
      else if (w_emit && r_rd_eop)
        r_pass_cnt <= r_pass_cnt + LC_ONE;
`ifdef STIM_HOLD_LAST_EN
      if (w_emit) r_dout <= r_ram_q;
`else
      r_dout <= w_emit ? r_ram_q : '0;
`endif
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.pass_cnt   = r_pass_cnt;

endmodule

// File: tb/tb_dsp_stim_player.sv
// Directed bench for dsp_stim_player with a sample scoreboard.
// Expected samples are queued at start and popped on dout_valid.
module tb_dsp_stim_player;

  localparam int DW  = 64;
  localparam int AW  = 10;
  localparam int LCW = 16;

  logic clk;
  logic rst;

  dsp_stim_player_if #(.DW(DW), .AW(AW), .LCW(LCW)) bus ();

  dsp_stim_player #(.DW(DW), .AW(AW), .LCW(LCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mdl [2**AW];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] last_seen;
  logic [DW-1:0] exp_idle;
  int n_chk;
  int n_fail;
  int n_done;
  int n_valid;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock; observe outputs 1ns after the edge
  task automatic step();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (bus.done) n_done++;
    if (bus.dout_valid) begin
      n_valid++;
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("dout", bus.dout, e);
      last_seen = bus.dout;
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
    mdl[a]      = d;
  endtask

  task automatic go(input int l, input int nl,
                    input bit push);
    if (push)
      for (int p = 0; p < nl; p++)
        for (int k = 0; k < l; k++)
          sb.push_back(mdl[k]);
    bus.len    = (AW+1)'(l);
    bus.nloops = LCW'(nl);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while (bus.busy && i < max) begin
      step();
      i++;
    end
    chk("idle_timeout", DW'(bus.busy), '0);
  endtask

  initial begin
    int g;
    n_chk = 0; n_fail = 0; n_done = 0; n_valid = 0;
    last_seen = '0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.nloops = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_dout", bus.dout, '0);
    chk("rst_valid", DW'(bus.dout_valid), '0);
    chk("rst_busy", DW'(bus.busy), '0);
    chk("rst_done", DW'(bus.done), '0);
    chk("rst_pass", DW'(bus.pass_cnt), '0);

    // single pass
    for (int k = 0; k < 8; k++) wr(k, DW'(k + 1));
    n_done = 0;
    go(8, 1, 1'b1);
    chk("sp_busy", DW'(bus.busy), 1);
    step();
    chk("sp_lat_v0", DW'(bus.dout_valid), 0);
    step();
    chk("sp_first_v", DW'(bus.dout_valid), 1);
    chk("sp_pass0", DW'(bus.pass_cnt), 0);
    for (int i = 0; i < 7; i++) step();
    chk("sp_last_v", DW'(bus.dout_valid), 1);
    chk("sp_pass1", DW'(bus.pass_cnt), 1);
    step();
`ifdef STIM_HOLD_LAST_EN
    exp_idle = 64'd8;
`else
    exp_idle = 64'd0;
`endif
    chk("sp_done", DW'(bus.done), 1);
    chk("sp_vfall", DW'(bus.dout_valid), 0);
    chk("sp_bfall", DW'(bus.busy), 0);
    chk("sp_idle_dout", bus.dout, exp_idle);
    step();
    chk("sp_done_1cyc", DW'(n_done), 1);

    // loop wrap
    wr(0, 64'hA); wr(1, 64'hB); wr(2, 64'hC);
    n_done = 0;
    go(3, 2, 1'b1);
    chk("lw_pass_clr", DW'(bus.pass_cnt), 0);
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lw_contig", DW'(bus.dout_valid), 1);
      if (i == 2) chk("lw_pass1", DW'(bus.pass_cnt), 1);
      if (i == 5) chk("lw_pass2", DW'(bus.pass_cnt), 2);
    end
    step(); step(); step();
    chk("lw_one_done", DW'(n_done), 1);

    // infinite then abort after 10 samples
    for (int k = 0; k < 4; k++) wr(k, DW'(k + 1));
    for (int i = 0; i < 10; i++) sb.push_back(mdl[i % 4]);
    n_done = 0;
    go(4, 0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) step();
    chk("inf_10th_v", DW'(bus.dout_valid), 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
`ifdef STIM_HOLD_LAST_EN
    exp_idle = 64'd2;
`else
    exp_idle = 64'd0;
`endif
    chk("ab_vdrop", DW'(bus.dout_valid), 0);
    chk("ab_busy", DW'(bus.busy), 0);
    chk("ab_dout", bus.dout, exp_idle);
    step(); step();
    chk("ab_no_done", DW'(n_done), 0);
    chk("ab_sb_empty", DW'(sb.size()), 0);

    // len=0 ignored
    go(0, 1, 1'b0);
    chk("l0_busy", DW'(bus.busy), 0);
    step(); step(); step();
    chk("l0_no_done", DW'(n_done), 0);

    // len=1, five passes
    go(1, 5, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l1_valid", DW'(bus.dout_valid), 1);
    end
    step();
    chk("l1_done", DW'(bus.done), 1);
    chk("l1_pass5", DW'(bus.pass_cnt), 5);

    // full depth
    for (int k = 0; k < 2**AW; k++)
      wr(k, 64'h1000 + DW'(k));
    n_valid = 0;
    go(2**AW, 1, 1'b1);
    wait_idle(2**AW + 20);
    chk("fd_count", DW'(n_valid), DW'(2**AW));
    chk("fd_last", last_seen, mdl[2**AW - 1]);

    // start during busy ignored, start in done cycle
    go(4, 1, 1'b1);
    step();
    bus.len = 11'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    g = 0;
    while (!bus.done && g < 20) begin
      step();
      g++;
    end
    chk("sc_done_seen", DW'(bus.done), 1);
    go(2, 1, 1'b1);
    chk("sc_restart", DW'(bus.busy), 1);
    step();
    chk("sc_lat_v0", DW'(bus.dout_valid), 0);
    step();
    chk("sc_lat_v1", DW'(bus.dout_valid), 1);
    wait_idle(10);

    // start and stop together in IDLE
    bus.stop = 1'b1;
    go(2, 1, 1'b1);
    bus.stop = 1'b0;
    chk("ss_busy", DW'(bus.busy), 1);
    wait_idle(10);

    // stop coincident with the last sample
    n_done = 0;
    go(2, 1, 1'b1);
    step(); step(); step();
    chk("sl_last_v", DW'(bus.dout_valid), 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("sl_no_done", DW'(n_done), 0);
    chk("sl_busy", DW'(bus.busy), 0);

    // live writes during play
    for (int k = 0; k < 8; k++) wr(k, 64'h100 + DW'(k));
    for (int k = 0; k < 8; k++)
      sb.push_back(k == 6 ? 64'hBEEF6 : mdl[k]);
    go(8, 1, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 10'd6;
    bus.wr_data = 64'hBEEF6;
    step();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.wr_en = 1'b1; bus.wr_addr = 10'd5;
    bus.wr_data = 64'hBEEF5;
    step();
    bus.wr_en = 1'b0;
    mdl[5] = 64'hBEEF5; mdl[6] = 64'hBEEF6;
    wait_idle(20);
    chk("lw_sb_empty", DW'(sb.size()), 0);

    // reset mid-run
    sb.push_back(mdl[0]); sb.push_back(mdl[1]);
    sb.push_back(mdl[0]);
    go(2, 0, 1'b0);
    step(); step(); step();
    chk("rm_pass1", DW'(bus.pass_cnt), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_dout", bus.dout, '0);
    chk("rm_valid", DW'(bus.dout_valid), 0);
    chk("rm_busy", DW'(bus.busy), 0);
    chk("rm_done", DW'(bus.done), 0);
    chk("rm_pass", DW'(bus.pass_cnt), 0);
    chk("end_sb_empty", DW'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_stim_player.md
Name: dsp_stim_player

Overview:
- Stimulus source for the DSP debug path; the drive-side counterpart of the capture ILA.
- Host preloads a sample RAM. On start, the block streams the samples back-to-back, one per clock, into the DSP datapath under test.
- Supports single-shot, N-pass and infinite looping, plus abort.
- Sits beside the ILA probe set so captured traffic can be replayed.

Parameters:
- DW, 64, sample width in bits.
- AW, 10, RAM address width; depth = 2**AW samples.
- LCW, 16, loop-count width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  RAM write strobe.
- wr_addr  input  AW  RAM write address.
- wr_data  input  DW  RAM write data.
- len  input  AW+1  samples per pass, valid 1..2**AW; latched at start.
- nloops  input  LCW  passes to play; 0 = infinite until stop; latched at start.
- start  input  1  single-cycle start request.
- stop  input  1  single-cycle abort request.
- dout  output  DW  sample to DSP.
- dout_valid  output  1  dout carries a sample.
- busy  output  1  high from the start-accept cycle until done or abort.
- done  output  1  one-cycle pulse at normal completion.
- pass_cnt  output  LCW  completed passes; wraps modulo 2**LCW.

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, busy=0, done=0, pass_cnt=0; FSM in IDLE.
  - RAM contents are not cleared.
- RAM:
  - Simple dual-port, 1-cycle registered read.
  - Writes are accepted in every state, including during play.
  - Same-address read and write in one cycle: read returns old data (read-first).
- FSM states: IDLE, PLAY, DRAIN.
- IDLE:
  - Start accepted when start=1 and len!=0 at edge T: latch len and nloops; raddr=0; busy=1 from T+1; pass_cnt cleared to 0; go to PLAY.
  - start with len=0 is ignored; state and outputs unchanged.
- PLAY:
  - raddr increments each cycle. At raddr==len_l-1 it wraps to 0 and the pass counter increments.
  - When the final pass's last address is issued, go to DRAIN.
  - nloops=0 never ends a pass sequence by count.
- DRAIN: wait for in-flight reads to emerge, then return to IDLE.
- Latency and streaming:
  - First sample (addr 0) appears on dout with dout_valid=1 in the cycle after edge T+2.
  - Thereafter one sample per cycle with no gaps, including across the wrap from len_l-1 to 0.
  - pass_cnt increments in the cycle the last sample of a pass is on dout.
- Normal completion:
  - dout_valid falls the cycle after the last sample.
  - done=1 in that same cycle, for exactly one cycle.
  - busy falls in that same cycle.
- Total sample count:
  - len_l * nloops_l samples per run; the total must fit 2**(AW+LCW).
  - len=1 repeats addr 0 every cycle.
- stop:
  - Effective in PLAY or DRAIN.
  - From the edge it is sampled: dout_valid=0, busy=0, go to IDLE, in-flight reads discarded, done not pulsed.
  - stop in IDLE has no effect.
- Simultaneous events:
  - start and stop together in IDLE: start wins.
  - start while busy is ignored; a start coincident with the done cycle is accepted.
  - stop coincident with the last sample: that sample still shows valid, done is suppressed.
- rst mid-run forces the reset values on the next edge.
- dout when dout_valid=0 is governed by the optional feature below.

Optional Feature:
- Macro: STIM_HOLD_LAST_EN.
- Defined: when dout_valid=0, dout holds the last valid sample, including after stop and done. Reset still clears dout to 0.
- Undefined: dout is forced to 0 whenever dout_valid=0.

Test Plan:
- Single pass: write addr k = k+1 for k=0..7; len=8, nloops=1; start at cycle 0.
  - dout = 1..8 valid on cycles 2..9.
  - done=1 and dout_valid=0 on cycle 10; pass_cnt=1.
- Loop wrap: len=3 (data 0xA,0xB,0xC), nloops=2.
  - dout = A,B,C,A,B,C contiguous with no gap.
  - pass_cnt goes 1 then 2; single done pulse.
- Infinite and abort: nloops=0, len=4; stop after 10 valid samples.
  - dout_valid drops the next cycle; busy=0; no done pulse.
  - dout=0 (macro off) or equals the 10th sample, value 0x2 (macro on).
- Corners:
  - len=0 start: busy stays 0, no done.
  - len=1, nloops=5: five cycles of the addr 0 sample.
  - len=1024: full depth plays, the last sample is from addr 1023.
- Start collisions:
  - start during busy is ignored.
  - start in the done cycle restarts, with the first sample two cycles later.
  - start and stop together in IDLE: run begins.
- Live write and reset:
  - Writing addr 5 while raddr=5 on the same cycle: old value is played.
  - Writing addr 6 earlier in the same pass: new value is played.
  - rst mid-run: all outputs 0 next cycle.
